// File: rtl/calc_sequencer.sv
// Calculator control sequencer: synchronises and debounces the execute button,
// snapshots op/operand, waits out ALU latency, then strobes the accumulator.
module calc_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ALU_LATENCY     = 2,
  parameter logic [3:0]  MAX_OP          = 4'h9
) (
  input  logic        clk,
  input  logic        btnac,
  input  logic        btnc,
  input  logic [3:0]  op_sel,
  input  logic [15:0] sw,
  input  logic        alu_ovf,
  output logic [3:0]  alu_op,
  output logic [15:0] operand_b,
  output logic        acc_load,
  output logic        busy,
  output logic        ovf_flag,
  output logic        err_flag,
  output logic [7:0]  op_count
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned WW  = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [DBW-1:0]  db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            db_prev_q;
  logic            press;
  logic [WW-1:0]   wait_q, wait_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [15:0]     operand_b_q, operand_b_d;
  logic            acc_load_q, acc_load_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [7:0]      count_q, count_d;

  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (sync_q[1] == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
      // This cycle is the DEBOUNCE_CYCLES-th consecutive differing sample.
      db_level_d = ~db_level_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign press = db_level_q & ~db_prev_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    alu_op_d    = alu_op_q;
    operand_b_d = operand_b_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          if (op_sel <= MAX_OP) begin
            alu_op_d    = op_sel;
            operand_b_d = sw;
            err_d       = 1'b0;
            wait_d      = WW'(ALU_LATENCY - 1);
            state_d     = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      EXEC: begin
        if (wait_q == '0) state_d = COMMIT;
        else              wait_d  = wait_q - 1'b1;
      end
      COMMIT: begin
        ovf_d   = ovf_q | alu_ovf;
        count_d = count_q + 8'd1;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!db_level_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobe and busy are registered from the next state so they align with it.
    acc_load_d = (state_d == COMMIT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (btnac) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      db_prev_q   <= 1'b0;
      wait_q      <= '0;
      alu_op_q    <= '0;
      operand_b_q <= '0;
      acc_load_q  <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], btnc};
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_level_q;
      wait_q      <= wait_d;
      alu_op_q    <= alu_op_d;
      operand_b_q <= operand_b_d;
      acc_load_q  <= acc_load_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign operand_b = operand_b_q;
  assign acc_load  = acc_load_q;
  assign busy      = busy_q;
  assign ovf_flag  = ovf_q;
  assign err_flag  = err_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with DEBOUNCE_CYCLES=4, ALU_LATENCY=2.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        btnac, btnc, alu_ovf;
  logic [3:0]  op_sel;
  logic [15:0] sw;
  logic [3:0]  alu_op;
  logic [15:0] operand_b;
  logic        acc_load, busy, ovf_flag, err_flag;
  logic [7:0]  op_count;

  calc_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LATENCY(2), .MAX_OP(4'h9)) dut (
    .clk(clk), .btnac(btnac), .btnc(btnc), .op_sel(op_sel), .sw(sw),
    .alu_ovf(alu_ovf), .alu_op(alu_op), .operand_b(operand_b),
    .acc_load(acc_load), .busy(busy), .ovf_flag(ovf_flag),
    .err_flag(err_flag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] b;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        prev_load = 1'b0;
  logic [3:0]  cur_op;
  logic [15:0] cur_b;
  logic [7:0]  exp_count;
  logic        exp_ovf, exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (acc_load) begin
      chk("load_not_consecutive", prev_load, 1'b0);
      if (sbq.size() == 0) begin
        chk("unexpected_load", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("load_alu_op", alu_op, e.op);
        chk("load_operand_b", operand_b, e.b);
        chk("load_count_before", op_count, e.cnt);
        chk("load_latency_cycle", cyc, e.cyc);
      end
    end
    prev_load <= acc_load;
  end

  task automatic model_reset();
    cur_op = '0; cur_b = '0; exp_count = '0; exp_ovf = 1'b0; exp_err = 1'b0;
  endtask

  task automatic check_status(input string pfx);
    chk({pfx, "_count"}, op_count, exp_count);
    chk({pfx, "_ovf"}, ovf_flag, exp_ovf);
    chk({pfx, "_err"}, err_flag, exp_err);
    chk({pfx, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_press(input logic [3:0] op, input logic [15:0] b, input logic ovf,
                          input int hold, input bit chg_sw, input string pfx);
    exp_t e;
    op_sel = op; sw = b; alu_ovf = ovf;
    @(posedge clk); #1;
    if (op <= 4'h9) begin
      e.op = op; e.b = b; e.cnt = exp_count; e.cyc = cyc + 9;
      sbq.push_back(e);
      cur_op = op; cur_b = b; exp_count = exp_count + 8'd1;
      exp_ovf = exp_ovf | ovf; exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    btnc = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (chg_sw && i == 6) sw = 16'hFFFF;
    end
    chk({pfx, "_busy_held"}, busy, 1'b1);
    chk({pfx, "_alu_op_held"}, alu_op, cur_op);
    chk({pfx, "_operand_b_held"}, operand_b, cur_b);
    btnc = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check_status(pfx);
  endtask

  initial begin
    btnac = 1'b1; btnc = 1'b1; op_sel = '0; sw = '0; alu_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_op", alu_op, 4'h0);
    chk("rst_operand_b", operand_b, 16'h0);
    chk("rst_acc_load", acc_load, 1'b0);
    check_status("rst");
    btnac = 1'b0; btnc = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_status("post_rst");

    do_press(4'h3, 16'h00A5, 1'b0, 20, 1'b0, "clean");

    for (int k = 0; k < 5; k++) begin
      btnc = 1'b1; repeat (3) @(posedge clk);
      #1;
      btnc = 1'b0; repeat (3) @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
    check_status("bounce");
    do_press(4'h5, 16'h1234, 1'b0, 10, 1'b0, "after_bounce");

    do_press(4'hC, 16'h5555, 1'b0, 12, 1'b0, "illegal");
    do_press(4'h1, 16'h0F0F, 1'b0, 12, 1'b0, "legal_after_err");

    do_press(4'h7, 16'h0042, 1'b1, 12, 1'b1, "sw_chg_ovf");
    do_press(4'h2, 16'h0003, 1'b0, 12, 1'b0, "ovf_sticky");

    btnac = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btnac = 1'b0;
    model_reset();
    chk("clr_alu_op", alu_op, 4'h0);
    check_status("clr");

    for (int n = 0; n < 256; n++) begin
      do_press(4'(n % 10), 16'(n * 257), 1'b0, 10, 1'b0, "wrap_loop");
    end
    chk("wrap_count", op_count, 8'h00);

    op_sel = 4'h4; sw = 16'hBEEF;
    @(posedge clk); #1;
    btnc = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("midexec_busy", busy, 1'b1);
    btnac = 1'b1; btnc = 1'b0;
    @(posedge clk); #1;
    btnac = 1'b0;
    model_reset();
    repeat (20) @(posedge clk);
    #1;
    check_status("midexec_abort");

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
